// File: rtl/dp_queue_pkg.sv
// Shared rename/dispatch definitions (package sys_defs).
// Holds the renamed packet and CDB broadcast types, the physical register
// tag width, the hard-wired zero register tag and the default depth of the
// rename-to-dispatch decoupling queue.
package sys_defs;

  localparam int PREG_IDX_WIDTH = 6;
  localparam logic [PREG_IDX_WIDTH-1:0] ZERO_PREG = '0;
  localparam int DP_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic                      valid;
    logic [31:0]               PC;
    logic [PREG_IDX_WIDTH-1:0] dest_preg;
    logic [PREG_IDX_WIDTH-1:0] rs1_preg;
    logic                      rs1_ready;
    logic [PREG_IDX_WIDTH-1:0] rs2_preg;
    logic                      rs2_ready;
  } RN_DP_PACKET;

  typedef struct packed {
    logic                      valid;
    logic [PREG_IDX_WIDTH-1:0] tag;
  } CDB_PACKET;

endpackage

// File: rtl/dp_queue_if.sv
// Rename/dispatch side of dp_queue.
// Handshake: rename offers up to two packets on rn_packet_in (lane 0 older,
// each lane qualified by its own .valid). Every valid lane is accepted in the
// cycle rn_stall is low; when rn_stall is high rename must hold the packets
// and its freelist/RAT state. On the dispatch side dp_packet_out[0..1] show
// the two oldest entries (.valid qualifies each), and dispatch consumes
// dp_take_cnt of them at the next edge.
// Modports: slave = the queue, master = rename + dispatch.
interface dp_queue_if
  import sys_defs::*;
#(
  parameter int DEPTH = DP_QUEUE_DEPTH
) ();

  RN_DP_PACKET [1:0]        rn_packet_in;
  logic                     rn_stall;
  RN_DP_PACKET [1:0]        dp_packet_out;
  logic [1:0]               dp_take_cnt;
  logic [$clog2(DEPTH):0]   dpq_count;

  modport slave (
    input  rn_packet_in,
    input  dp_take_cnt,
    output rn_stall,
    output dp_packet_out,
    output dpq_count
  );

  modport master (
    output rn_packet_in,
    output dp_take_cnt,
    input  rn_stall,
    input  dp_packet_out,
    input  dpq_count
  );

endinterface

// File: rtl/dpq_tag_match.sv
// CDB tag comparator.
// Ports: tag  - physical register tag to test
//        cdb  - both CDB broadcast lanes
//        hit  - 1 when a valid CDB lane carries this tag; the zero register
//               never matches, so its ready bit stays as rename supplied it.
module dpq_tag_match
  import sys_defs::*;
(
  input  logic [PREG_IDX_WIDTH-1:0] tag,
  input  CDB_PACKET [1:0]           cdb,
  output logic                      hit
);

  assign hit = (tag != ZERO_PREG) &&
               ((cdb[0].valid && (cdb[0].tag == tag)) ||
                (cdb[1].valid && (cdb[1].tag == tag)));

endmodule

// File: rtl/dp_queue.sv
// Two-wide in-order rename-to-dispatch queue.
// Ports: clock, reset (async, active-low), rollback_en (flush),
//        cdb_packet_in (wakeup broadcasts), dpq (dp_queue_if.slave: rename
//        packets in, rn_stall out, dispatch packets out, dp_take_cnt in,
//        dpq_count out).
// Circular buffer with head/tail/count. Waiting packets pick up CDB wakeups;
// the outputs also OR in the same-cycle CDB match so dispatch sees a wakeup
// in the broadcast cycle.
module dp_queue
  import sys_defs::*;
#(
  parameter int DEPTH = DP_QUEUE_DEPTH
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rollback_en,
  input  CDB_PACKET [1:0] cdb_packet_in,
  dp_queue_if.slave       dpq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  RN_DP_PACKET        entries [DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;

  logic [1:0]         lane_v;
  logic               enq_ok;
  logic [CNT_W-1:0]   enq_n;
  logic [CNT_W-1:0]   take_req, take;
  logic [PTR_W-1:0]   slot1;

  logic [DEPTH-1:0]   res_hit1, res_hit2;
  logic [1:0]         enq_hit1, enq_hit2, byp_hit1, byp_hit2;
  RN_DP_PACKET        enq_pkt [2];
  RN_DP_PACKET        out_raw [2];

  // Stall looks only at registered count: a same-cycle dequeue never
  // releases it, which keeps rn_stall free of input-to-output paths.
  assign dpq.rn_stall  = (CNT_W'(DEPTH) - count) < CNT_W'(2);
  assign dpq.dpq_count = count;

  assign lane_v   = {dpq.rn_packet_in[1].valid, dpq.rn_packet_in[0].valid};
  assign enq_ok   = !dpq.rn_stall && !rollback_en;
  assign enq_n    = enq_ok ? (CNT_W'(lane_v[0]) + CNT_W'(lane_v[1])) : '0;
  assign take_req = CNT_W'(dpq.dp_take_cnt);
  assign take     = (take_req > count) ? count : take_req;
  // Lane 1 compacts down to tail when lane 0 is empty.
  assign slot1    = tail + PTR_W'(lane_v[0]);

  // Resident wakeup. Free slots may also pick up ready bits; that is
  // harmless because enqueue overwrites the whole entry.
  for (genvar e = 0; e < DEPTH; e++) begin : g_res
    dpq_tag_match u_res1 (.tag(entries[e].rs1_preg), .cdb(cdb_packet_in), .hit(res_hit1[e]));
    dpq_tag_match u_res2 (.tag(entries[e].rs2_preg), .cdb(cdb_packet_in), .hit(res_hit2[e]));
  end

  for (genvar l = 0; l < 2; l++) begin : g_lane
    dpq_tag_match u_enq1 (.tag(dpq.rn_packet_in[l].rs1_preg), .cdb(cdb_packet_in), .hit(enq_hit1[l]));
    dpq_tag_match u_enq2 (.tag(dpq.rn_packet_in[l].rs2_preg), .cdb(cdb_packet_in), .hit(enq_hit2[l]));

    assign out_raw[l] = entries[head + PTR_W'(l)];

    dpq_tag_match u_byp1 (.tag(out_raw[l].rs1_preg), .cdb(cdb_packet_in), .hit(byp_hit1[l]));
    dpq_tag_match u_byp2 (.tag(out_raw[l].rs2_preg), .cdb(cdb_packet_in), .hit(byp_hit2[l]));
  end

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      enq_pkt[l]           = dpq.rn_packet_in[l];
      enq_pkt[l].rs1_ready = dpq.rn_packet_in[l].rs1_ready | enq_hit1[l];
      enq_pkt[l].rs2_ready = dpq.rn_packet_in[l].rs2_ready | enq_hit2[l];
    end
  end

  // Output depends on registered state and the CDB only, never on
  // dp_take_cnt, so dispatch may compute its take from these packets.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dpq.dp_packet_out[i] = '0;
      if (CNT_W'(i) < count) begin
        dpq.dp_packet_out[i]           = out_raw[i];
        dpq.dp_packet_out[i].rs1_ready = out_raw[i].rs1_ready | byp_hit1[i];
        dpq.dp_packet_out[i].rs2_ready = out_raw[i].rs2_ready | byp_hit2[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int e = 0; e < DEPTH; e++) entries[e] <= '0;
    end else if (rollback_en) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (res_hit1[e]) entries[e].rs1_ready <= 1'b1;
        if (res_hit2[e]) entries[e].rs2_ready <= 1'b1;
      end
      // Enqueue writes come after the wakeup loop so a fresh packet wins.
      if (enq_ok && lane_v[0]) entries[tail]  <= enq_pkt[0];
      if (enq_ok && lane_v[1]) entries[slot1] <= enq_pkt[1];
      head  <= head + PTR_W'(take);
      tail  <= tail + PTR_W'(enq_n);
      count <= count - take + enq_n;
    end
  end

endmodule

// File: tb/tb_dp_queue.sv
// Directed bench for dp_queue (DEPTH = 4).
module tb_dp_queue;
  import sys_defs::*;

  localparam int DEPTH = 4;

  logic            clock;
  logic            reset;
  logic            rollback_en;
  CDB_PACKET [1:0] cdb_packet_in;

  dp_queue_if #(.DEPTH(DEPTH)) dpq ();

  dp_queue #(.DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .rollback_en   (rollback_en),
    .cdb_packet_in (cdb_packet_in),
    .dpq           (dpq)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          exp_cnt;
  int          checks;
  int          failures;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic RN_DP_PACKET mk(input logic [31:0] pc,
                                     input logic [5:0] r1, input logic k1,
                                     input logic [5:0] r2, input logic k2);
    RN_DP_PACKET p;
    p           = '0;
    p.valid     = 1'b1;
    p.PC        = pc;
    p.dest_preg = 6'd33;
    p.rs1_preg  = r1;
    p.rs1_ready = k1;
    p.rs2_preg  = r2;
    p.rs2_ready = k2;
    return p;
  endfunction

  function automatic RN_DP_PACKET rdy(input logic [31:0] pc);
    return mk(pc, 6'd1, 1'b1, 6'd2, 1'b1);
  endfunction

  task automatic clear_inputs();
    dpq.rn_packet_in = '0;
    dpq.dp_take_cnt  = 2'd0;
    cdb_packet_in    = '0;
    rollback_en      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    exp_q.delete();
    exp_cnt = 0;
    #12;
    reset = 1'b1;
    tick();
  endtask

  // One cycle: offer two lanes and a take. Stall rule used by the model:
  // rename is accepted only while at least two slots were free at the edge.
  task automatic run_cycle(input RN_DP_PACKET p0, input RN_DP_PACKET p1, input int take);
    int eff;
    bit acc;
    dpq.rn_packet_in[0] = p0;
    dpq.rn_packet_in[1] = p1;
    dpq.dp_take_cnt     = 2'(take);
    #1;
    eff = (take > exp_cnt) ? exp_cnt : take;
    acc = (exp_cnt <= DEPTH - 2);
    for (int i = 0; i < eff; i++) begin
      check_eq("out_valid", 64'(dpq.dp_packet_out[i].valid), 64'(1));
      check_eq("out_pc", 64'(dpq.dp_packet_out[i].PC), 64'(exp_q[i]));
    end
    tick();
    for (int i = 0; i < eff; i++) void'(exp_q.pop_front());
    exp_cnt -= eff;
    if (acc) begin
      if (p0.valid) begin exp_q.push_back(p0.PC); exp_cnt++; end
      if (p1.valid) begin exp_q.push_back(p1.PC); exp_cnt++; end
    end
    clear_inputs();
    #1;
    check_eq("count", 64'(dpq.dpq_count), 64'(exp_cnt));
    check_eq("rn_stall", 64'(dpq.rn_stall), 64'(exp_cnt >= DEPTH - 1));
    if (exp_cnt > 0) check_eq("head_pc", 64'(dpq.dp_packet_out[0].PC), 64'(exp_q[0]));
    else             check_eq("empty_v0", 64'(dpq.dp_packet_out[0].valid), 64'(0));
  endtask

  RN_DP_PACKET none;

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    failures = 0;
    none     = '0;
    exp_cnt  = 0;
    reset    = 1'b0;
    clear_inputs();
    #3;
    check_eq("rst_count", 64'(dpq.dpq_count), 64'(0));
    check_eq("rst_stall", 64'(dpq.rn_stall), 64'(0));
    check_eq("rst_out0", 64'(dpq.dp_packet_out[0]), 64'(0));
    check_eq("rst_out1", 64'(dpq.dp_packet_out[1]), 64'(0));
    #9;
    reset = 1'b1;
    tick();

    // Basic fill: two, two more (stall at 4), refused offer, drain.
    run_cycle(rdy(32'h100), rdy(32'h104), 0);
    check_eq("basic_pc1", 64'(dpq.dp_packet_out[1].PC), 64'(32'h104));
    check_eq("basic_cnt2", 64'(dpq.dpq_count), 64'(2));
    check_eq("basic_nostall", 64'(dpq.rn_stall), 64'(0));
    run_cycle(rdy(32'h108), rdy(32'h10c), 0);
    check_eq("full_stall", 64'(dpq.rn_stall), 64'(1));
    run_cycle(rdy(32'h110), rdy(32'h114), 0);
    check_eq("full_cnt", 64'(dpq.dpq_count), 64'(4));
    run_cycle(none, none, 2);
    run_cycle(none, none, 2);

    // Wakeup: resident bypass, stored wakeup, enqueue wakeup, zero tag.
    run_cycle(mk(32'h200, 6'd17, 1'b0, 6'd0, 1'b0), none, 0);
    check_eq("wk_pre", 64'(dpq.dp_packet_out[0].rs1_ready), 64'(0));
    cdb_packet_in[1]    = '{valid: 1'b1, tag: 6'd17};
    cdb_packet_in[0]    = '{valid: 1'b1, tag: 6'd9};
    dpq.rn_packet_in[0] = mk(32'h204, 6'd9, 1'b0, 6'd17, 1'b0);
    #1;
    check_eq("wk_bypass", 64'(dpq.dp_packet_out[0].rs1_ready), 64'(1));
    check_eq("wk_bypass_rs2", 64'(dpq.dp_packet_out[0].rs2_ready), 64'(0));
    tick();
    clear_inputs();
    exp_q.push_back(32'h204);
    exp_cnt = 2;
    #1;
    check_eq("wk_stored", 64'(dpq.dp_packet_out[0].rs1_ready), 64'(1));
    check_eq("wk_enq_rs1", 64'(dpq.dp_packet_out[1].rs1_ready), 64'(1));
    check_eq("wk_enq_rs2", 64'(dpq.dp_packet_out[1].rs2_ready), 64'(1));
    check_eq("wk_enq_pc", 64'(dpq.dp_packet_out[1].PC), 64'(32'h204));
    cdb_packet_in[0] = '{valid: 1'b1, tag: ZERO_PREG};
    #1;
    check_eq("zero_bypass", 64'(dpq.dp_packet_out[0].rs2_ready), 64'(0));
    tick();
    clear_inputs();
    #1;
    check_eq("zero_stored", 64'(dpq.dp_packet_out[0].rs2_ready), 64'(0));
    run_cycle(none, none, 2);

    // Compaction: only lane 1 valid.
    run_cycle(none, rdy(32'h40), 0);
    check_eq("compact_pc", 64'(dpq.dp_packet_out[0].PC), 64'(32'h40));
    check_eq("compact_v1", 64'(dpq.dp_packet_out[1].valid), 64'(0));
    // Clipped takes: 2 with one entry, then 2 with none.
    run_cycle(none, none, 2);
    run_cycle(none, none, 2);
    check_eq("clip_cnt", 64'(dpq.dpq_count), 64'(0));

    // Wrap: reach head=3/count=3, refused offer, then wrap tail.
    do_reset();
    run_cycle(rdy(32'h300), rdy(32'h304), 0);
    run_cycle(rdy(32'h308), rdy(32'h30c), 0);
    run_cycle(none, none, 2);
    run_cycle(none, none, 1);
    run_cycle(rdy(32'h310), rdy(32'h314), 0);
    check_eq("wrap_cnt3", 64'(dpq.dpq_count), 64'(3));
    check_eq("wrap_head", 64'(dpq.dp_packet_out[0].PC), 64'(32'h30c));
    run_cycle(rdy(32'h318), rdy(32'h31c), 0);
    run_cycle(none, none, 2);
    run_cycle(rdy(32'h320), rdy(32'h324), 0);
    run_cycle(none, none, 2);
    check_eq("wrap_order", 64'(dpq.dp_packet_out[0].PC), 64'(32'h324));
    run_cycle(none, none, 2);

    // Simultaneous enqueue and dequeue, reaching count 3.
    run_cycle(rdy(32'h400), rdy(32'h404), 0);
    run_cycle(rdy(32'h408), rdy(32'h40c), 1);
    check_eq("simul_cnt", 64'(dpq.dpq_count), 64'(3));

    // Rollback beats enqueue and dequeue.
    dpq.rn_packet_in[0] = rdy(32'h500);
    dpq.rn_packet_in[1] = rdy(32'h504);
    dpq.dp_take_cnt     = 2'd2;
    rollback_en         = 1'b1;
    tick();
    clear_inputs();
    exp_q.delete();
    exp_cnt = 0;
    #1;
    check_eq("rb_count", 64'(dpq.dpq_count), 64'(0));
    check_eq("rb_v0", 64'(dpq.dp_packet_out[0].valid), 64'(0));
    check_eq("rb_v1", 64'(dpq.dp_packet_out[1].valid), 64'(0));
    check_eq("rb_stall", 64'(dpq.rn_stall), 64'(0));
    run_cycle(rdy(32'h600), rdy(32'h604), 0);

    // Asynchronous reset mid-traffic, checked between clock edges.
    dpq.rn_packet_in[0] = rdy(32'h700);
    dpq.rn_packet_in[1] = rdy(32'h704);
    dpq.dp_take_cnt     = 2'd1;
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check_eq("arst_count", 64'(dpq.dpq_count), 64'(0));
    check_eq("arst_stall", 64'(dpq.rn_stall), 64'(0));
    check_eq("arst_out0", 64'(dpq.dp_packet_out[0]), 64'(0));
    check_eq("arst_out1", 64'(dpq.dp_packet_out[1]), 64'(0));
    clear_inputs();
    exp_q.delete();
    exp_cnt = 0;
    #10;
    reset = 1'b1;
    tick();
    run_cycle(rdy(32'h800), none, 0);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
